// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state codes and grant encoding for the fetch / load-store
// single-port RAM arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    MEM_ARB_IDLE     = 2'd0,
    MEM_ARB_IF_WAIT  = 2'd1,
    MEM_ARB_MEM_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-port RAM.
// Each access is a grant cycle followed by one wait cycle carrying the ready pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              mem_req_i,
  input  logic              mem_wen_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_ready_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              stall_o
);

  arb_state_t state_reg, state_next;
  grant_t     last_grant_reg, last_grant_next;
  logic       store_reg, store_next;
  logic       grant_mem, grant_if;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= MEM_ARB_IDLE;
      last_grant_reg <= GRANT_IF;
      store_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      store_reg      <= store_next;
    end
  end

  // On a conflict the port that did not win last time gets the RAM.
  assign grant_mem = mem_req_i & (~if_req_i | (last_grant_reg == GRANT_IF));
  assign grant_if  = if_req_i & ~grant_mem;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    store_next      = store_reg;
    if_ready_o      = 1'b0;
    if_rdata_o      = '0;
    mem_ready_o     = 1'b0;
    mem_rdata_o     = '0;
    ram_en_o        = 1'b0;
    ram_we_o        = 1'b0;
    ram_addr_o      = '0;
    ram_wdata_o     = '0;
    stall_o         = 1'b0;

    case (state_reg)
      MEM_ARB_IDLE: begin
        if (grant_mem) begin
          ram_en_o        = 1'b1;
          ram_we_o        = mem_wen_i;
          ram_addr_o      = mem_addr_i;
          ram_wdata_o     = mem_wdata_i;
          state_next      = MEM_ARB_MEM_WAIT;
          last_grant_next = GRANT_MEM;
          store_next      = mem_wen_i;
        end else if (grant_if) begin
          ram_en_o        = 1'b1;
          ram_addr_o      = if_addr_i;
          state_next      = MEM_ARB_IF_WAIT;
          last_grant_next = GRANT_IF;
        end
      end
      MEM_ARB_IF_WAIT: begin
        if_ready_o = 1'b1;
        if_rdata_o = ram_rdata_i;
        state_next = MEM_ARB_IDLE;
      end
      MEM_ARB_MEM_WAIT: begin
        // The store flag is captured at grant so a dropped request still completes correctly.
        mem_ready_o = 1'b1;
        mem_rdata_o = store_reg ? '0 : ram_rdata_i;
        state_next  = MEM_ARB_IDLE;
      end
      default: state_next = MEM_ARB_IDLE;
    endcase

    stall_o = (mem_req_i & ~mem_ready_o) | (if_req_i & ~if_ready_o);

    // Outputs are combinational from live inputs, so reset must mask them directly.
    if (rst) begin
      if_ready_o  = 1'b0;
      if_rdata_o  = '0;
      mem_ready_o = 1'b0;
      mem_rdata_o = '0;
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      stall_o     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM; expected read data is
// queued at issue time and checked by a monitor on each ready pulse.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic              if_ready_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              mem_req_i = 1'b0;
  logic              mem_wen_i = 1'b0;
  logic [ADDR_W-1:0] mem_addr_i = '0;
  logic [DATA_W-1:0] mem_wdata_i = '0;
  logic              mem_ready_o;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i = '0;
  logic              stall_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_if_q[$];
  logic [DATA_W-1:0] exp_mem_q[$];
  logic [DATA_W-1:0] ram [0:255];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_wen_i(mem_wen_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_ready_o(mem_ready_o), .mem_rdata_o(mem_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) ram[ram_addr_o[7:0]] <= ram_wdata_o;
      else          ram_rdata_i <= ram[ram_addr_o[7:0]];
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h at %0t", name, act, $time);
    end
  endtask

  // Scoreboard monitor: pops on each ready pulse, otherwise read data must be zero.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_ready_o && mem_ready_o) chk("ready_overlap", 16'd1, 16'd0);
      if (if_ready_o) begin
        if (exp_if_q.size() == 0) chk("if_unexpected_ready", 16'd1, 16'd0);
        else chk("if_rdata", if_rdata_o, exp_if_q.pop_front());
      end else if (if_rdata_o !== '0) begin
        chk("if_rdata_idle", if_rdata_o, 16'h0000);
      end
      if (mem_ready_o) begin
        if (exp_mem_q.size() == 0) chk("mem_unexpected_ready", 16'd1, 16'd0);
        else chk("mem_rdata", mem_rdata_o, exp_mem_q.pop_front());
      end else if (mem_rdata_o !== '0) begin
        chk("mem_rdata_idle", mem_rdata_o, 16'h0000);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mem(input logic wen, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp);
    step();
    mem_req_i = 1'b1; mem_wen_i = wen; mem_addr_i = addr; mem_wdata_i = wdata;
    exp_mem_q.push_back(exp);
    @(negedge clk);
    chk("mem_c0_en", ram_en_o, 16'd1);
    chk("mem_c0_we", ram_we_o, 16'(wen));
    chk("mem_c0_addr", ram_addr_o, addr);
    if (wen) chk("mem_c0_wdata", ram_wdata_o, wdata);
    chk("mem_c0_stall", stall_o, 16'd1);
    chk("mem_c0_ready", mem_ready_o, 16'd0);
    @(negedge clk);
    chk("mem_c1_ready", mem_ready_o, 16'd1);
    chk("mem_c1_stall", stall_o, 16'd0);
    chk("mem_c1_en", ram_en_o, 16'd0);
    step();
    mem_req_i = 1'b0; mem_wen_i = 1'b0;
  endtask

  task automatic do_if(input logic [15:0] addr, input logic [15:0] exp);
    step();
    if_req_i = 1'b1; if_addr_i = addr;
    exp_if_q.push_back(exp);
    @(negedge clk);
    chk("if_c0_en", ram_en_o, 16'd1);
    chk("if_c0_we", ram_we_o, 16'd0);
    chk("if_c0_addr", ram_addr_o, addr);
    chk("if_c0_ready", if_ready_o, 16'd0);
    @(negedge clk);
    chk("if_c1_ready", if_ready_o, 16'd1);
    chk("if_c1_stall", stall_o, 16'd0);
    step();
    if_req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int readies;
    for (int i = 0; i < 256; i++) ram[i] = 16'(i * 3);
    ram[8'h10] = 16'hBEEF;
    ram[8'h04] = 16'hA5A5;

    // Reset holds every output low even with requests present.
    if_req_i = 1'b1; mem_req_i = 1'b1; mem_addr_i = 16'h0010;
    #12;
    chk("rst_stall", stall_o, 16'd0);
    chk("rst_ram_en", ram_en_o, 16'd0);
    chk("rst_ready", {if_ready_o, mem_ready_o}, 16'd0);
    if_req_i = 1'b0; mem_req_i = 1'b0;
    step();
    rst = 1'b0;

    do_mem(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    do_mem(1'b1, 16'h0020, 16'h1234, 16'h0000);
    do_mem(1'b0, 16'h0020, 16'h0000, 16'h1234);
    do_if(16'h0004, 16'hA5A5);

    // Conflict straight after reset: MEM wins first.
    step(); rst = 1'b1; step(); rst = 1'b0;
    step();
    mem_req_i = 1'b1; mem_wen_i = 1'b0; mem_addr_i = 16'h0010;
    if_req_i = 1'b1; if_addr_i = 16'h0004;
    exp_mem_q.push_back(16'hBEEF);
    exp_if_q.push_back(16'hA5A5);
    @(negedge clk);
    chk("cf_c0_addr", ram_addr_o, 16'h0010);
    @(negedge clk);
    chk("cf_c1_mem_ready", mem_ready_o, 16'd1);
    chk("cf_c1_if_ready", if_ready_o, 16'd0);
    chk("cf_c1_stall", stall_o, 16'd1);
    step();
    mem_req_i = 1'b0;
    @(negedge clk);
    chk("cf_c2_addr", ram_addr_o, 16'h0004);
    chk("cf_c2_en", ram_en_o, 16'd1);
    @(negedge clk);
    chk("cf_c3_if_ready", if_ready_o, 16'd1);
    chk("cf_c3_mem_ready", mem_ready_o, 16'd0);
    step();
    if_req_i = 1'b0;

    // Both held for 8 cycles: grants alternate MEM, IF, MEM, IF.
    step();
    mem_req_i = 1'b1; if_req_i = 1'b1;
    exp_mem_q.push_back(16'hBEEF); exp_mem_q.push_back(16'hBEEF);
    exp_if_q.push_back(16'hA5A5);  exp_if_q.push_back(16'hA5A5);
    readies = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) chk($sformatf("alt_grant%0d", i), ram_addr_o,
                          (i % 4 == 0) ? 16'h0010 : 16'h0004);
      readies += int'(if_ready_o) + int'(mem_ready_o);
    end
    chk("alt_ready_count", 16'(readies), 16'd4);
    step();
    mem_req_i = 1'b0; if_req_i = 1'b0;

    // Fetch request dropped during the wait cycle still completes.
    step();
    if_req_i = 1'b1; if_addr_i = 16'h0004;
    exp_if_q.push_back(16'hA5A5);
    @(negedge clk);
    chk("drop_c0_en", ram_en_o, 16'd1);
    step();
    if_req_i = 1'b0;
    @(negedge clk);
    chk("drop_c1_ready", if_ready_o, 16'd1);

    // Reset during MEM_WAIT abandons the access.
    step();
    mem_req_i = 1'b1; mem_wen_i = 1'b0; mem_addr_i = 16'h0010;
    @(negedge clk);
    chk("ab_c0_en", ram_en_o, 16'd1);
    step();
    rst = 1'b1;
    #1;
    chk("ab_mem_ready", mem_ready_o, 16'd0);
    chk("ab_mem_rdata", mem_rdata_o, 16'h0000);
    chk("ab_ram_en", ram_en_o, 16'd0);
    chk("ab_stall", stall_o, 16'd0);
    mem_req_i = 1'b0;
    step(); step();
    rst = 1'b0;
    do_mem(1'b0, 16'h0020, 16'h0000, 16'h1234);

    step(); step();
    chk("if_queue_empty", 16'(exp_if_q.size()), 16'd0);
    chk("mem_queue_empty", 16'(exp_mem_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
